oam_dma: RTL and testbench

- Sprite OAM DMA engine for NES_ARCHITECUTRE; sits between the T65 CPU bus and the PPU register port.
- Triggered by a CPU write to $4014. Halts the CPU via RDY, then copies 256 bytes from CPU page $XX00-$XXFF to PPU $2004.
- Runs on MCLK; advances only on cpu_ce, a one-MCLK pulse marking the last MCLK of each CPU cycle.

---
 rtl/oam_dma.sv | 138 +++++++++++++
 tb/tb_oam_dma.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to TRIG_ADDR halts the CPU and copies XFER_LEN
// bytes from page {page,00} to OAM_PORT_ADDR as alternating read/write cycles.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR     = 16'h4014,
  parameter logic [15:0] OAM_PORT_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic        dma_we,
  output logic [7:0]  dma_wdata,
  input  logic [7:0]  dma_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(XFER_LEN - 1);

  state_t      state_q, state_d;
  logic        parity_q, parity_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cpu_rdy_q, cpu_rdy_d;
  logic        dma_active_q, dma_active_d;
  logic        dma_rd_q, dma_rd_d;
  logic        dma_we_q, dma_we_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_wdata_q, dma_wdata_d;

  always_comb begin
    state_d      = state_q;
    parity_d     = parity_q;
    page_d       = page_q;
    cnt_d        = cnt_q;
    cpu_rdy_d    = cpu_rdy_q;
    dma_active_d = dma_active_q;
    dma_rd_d     = dma_rd_q;
    dma_we_d     = dma_we_q;
    dma_addr_d   = dma_addr_q;
    dma_wdata_d  = dma_wdata_q;

    if (cpu_ce) begin
      parity_d = ~parity_q;

      case (state_q)
        S_IDLE: begin
          if (cpu_we && (cpu_addr == TRIG_ADDR)) begin
            page_d  = cpu_dout;
            cnt_d   = 8'd0;
            state_d = S_HALT;
          end
        end
        // The cycle after HALT has parity ~parity_q; reads must land on get (0) cycles.
        S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          dma_wdata_d = dma_rdata;
          state_d     = S_WRITE;
        end
        S_WRITE: begin
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_q == LAST_CNT) ? S_IDLE : S_READ;
        end
        default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they hold for the whole cycle.
      cpu_rdy_d    = 1'b0;
      dma_active_d = 1'b1;
      dma_rd_d     = 1'b0;
      dma_we_d     = 1'b0;
      dma_addr_d   = 16'h0000;
      case (state_d)
        S_IDLE: begin
          cpu_rdy_d    = 1'b1;
          dma_active_d = 1'b0;
        end
        S_READ: begin
          dma_rd_d   = 1'b1;
          dma_addr_d = {page_d, cnt_d};
        end
        S_WRITE: begin
          dma_we_d   = 1'b1;
          dma_addr_d = OAM_PORT_ADDR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      parity_q     <= 1'b0;
      page_q       <= 8'h00;
      cnt_q        <= 8'h00;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
      dma_rd_q     <= 1'b0;
      dma_we_q     <= 1'b0;
      dma_addr_q   <= 16'h0000;
      dma_wdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      parity_q     <= parity_d;
      page_q       <= page_d;
      cnt_q        <= cnt_d;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_active_q <= dma_active_d;
      dma_rd_q     <= dma_rd_d;
      dma_we_q     <= dma_we_d;
      dma_addr_q   <= dma_addr_d;
      dma_wdata_q  <= dma_wdata_d;
    end
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign dma_active = dma_active_q;
  assign dma_rd     = dma_rd_q;
  assign dma_we     = dma_we_q;
  assign dma_addr   = dma_addr_q;
  assign dma_wdata  = dma_wdata_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a scoreboard of expected per-CPU-cycle bus outputs,
// filled when a transfer is triggered and drained at every cpu_ce edge.
module tb_oam_dma;

  typedef struct packed {
    logic        rdy;
    logic        act;
    logic        rd;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } obs_t;

  logic        MCLK = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_ce = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_rdy, dma_active, dma_rd, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;

  int checks = 0;
  int failures = 0;
  int zero_page_hits = 0;
  bit tb_par = 1'b0;
  logic [27:0] exp_q[$];

  oam_dma dut (
    .MCLK(MCLK), .reset(reset), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
    .dma_active(dma_active), .dma_addr(dma_addr), .dma_rd(dma_rd),
    .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata)
  );

  // clock/reset
  always #5 MCLK = ~MCLK;

  initial begin
    #800000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Memory model: byte at {p,i} is i ^ A5 ^ p ^ 02 (page 2 gives i ^ A5).
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
  endfunction
  assign dma_rdata = mem_val(dma_addr);

  function automatic obs_t cur_obs();
    obs_t o;
    o.rdy = cpu_rdy; o.act = dma_active; o.rd = dma_rd; o.we = dma_we;
    o.addr = dma_addr; o.wdata = dma_wdata;
    return o;
  endfunction

  function automatic logic [27:0] mk(input logic rdy, input logic act, input logic rd,
                                     input logic we, input logic [15:0] addr,
                                     input logic [7:0] wd);
    obs_t o;
    o.rdy = rdy; o.act = act; o.rd = rd; o.we = we; o.addr = addr; o.wdata = wd;
    return o;
  endfunction

  // scoreboard: expected outputs of every CPU cycle of one transfer
  task automatic push_transfer(input logic [7:0] page, input bit align);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0));
    if (align) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0));
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, {page, 8'(i)}, 8'h0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 16'h2004, mem_val({page, 8'(i)})));
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0));
  endtask

  always @(posedge MCLK) begin
    if (cpu_ce && !reset) begin
      obs_t e, o;
      bit ok;
      #1;
      o = cur_obs();
      if (o.rd === 1'b1 && o.addr[15:8] == 8'h00) zero_page_hits++;
      checks++;
      if (exp_q.size() != 0) begin
        e = obs_t'(exp_q.pop_front());
        ok = (o.rdy === e.rdy) && (o.act === e.act) && (o.rd === e.rd) && (o.we === e.we);
        if (e.rd || e.we) ok = ok && (o.addr === e.addr);
        if (e.we) ok = ok && (o.wdata === e.wdata);
        if (!ok) begin
          failures++;
          $display("FAIL scoreboard t=%0t got rdy=%b act=%b rd=%b we=%b addr=%h wdata=%h exp rdy=%b act=%b rd=%b we=%b addr=%h wdata=%h",
                   $time, o.rdy, o.act, o.rd, o.we, o.addr, o.wdata,
                   e.rdy, e.act, e.rd, e.we, e.addr, e.wdata);
        end
      end else if (o.rdy !== 1'b1 || o.act !== 1'b0 || o.rd !== 1'b0 || o.we !== 1'b0) begin
        failures++;
        $display("FAIL idle_bus t=%0t got rdy=%b act=%b rd=%b we=%b exp rdy=1 act=0 rd=0 we=0",
                 $time, o.rdy, o.act, o.rd, o.we);
      end
    end
  end

  // driver: one CPU cycle of 'gap' MCLKs, cpu_ce on the last; outputs must hold before it
  task automatic cpu_cycle(input int gap, input logic [15:0] addr, input logic we,
                           input logic [7:0] dout);
    obs_t snap;
    snap = cur_obs();
    cpu_addr = addr; cpu_we = we; cpu_dout = dout;
    for (int k = 0; k < gap; k++) begin
      cpu_ce = (k == gap - 1);
      @(posedge MCLK); #2;
      if (k < gap - 1) begin
        checks++;
        if (cur_obs() !== snap) begin
          failures++;
          $display("FAIL hold_in_gap t=%0t got %h exp %h", $time, cur_obs(), snap);
        end
      end
    end
    cpu_ce = 1'b0; cpu_we = 1'b0;
    tb_par = ~tb_par;
  endtask

  task automatic apply_reset();
    cpu_ce = 1'b0; cpu_we = 1'b0;
    @(negedge MCLK); reset = 1'b1;
    repeat (2) @(posedge MCLK);
    #2 reset = 1'b0;
    exp_q.delete();
    tb_par = 1'b0;
  endtask

  task automatic trigger(input int gap, input logic [7:0] page);
    push_transfer(page, tb_par);
    cpu_cycle(gap, 16'h4014, 1'b1, page);
  endtask

  // driver: idle cycles while the CPU is halted; returns halted-cycle count (capped)
  task automatic run_halt(input bit irregular, output int n);
    int gap;
    n = 0;
    while (cpu_rdy !== 1'b1 && n < 600) begin
      gap = irregular ? ((n == 200) ? 40 : int'($urandom_range(11, 13))) : 3;
      cpu_cycle(gap, 16'h0000, 1'b0, 8'h00);
      n++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got %b exp 1", cpu_rdy); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL reset_active got %b exp 0", dma_active); end
    checks++; if (dma_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got %b exp 0", dma_rd); end
    checks++; if (dma_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b exp 0", dma_we); end
    checks++; if (dma_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got %h exp 0000", dma_addr); end
    checks++; if (dma_wdata !== 8'h0) begin failures++; $display("FAIL reset_wdata got %h exp 00", dma_wdata); end
  endtask

  task automatic test_parity0();
    int n;
    apply_reset();
    cpu_cycle(3, 16'h0000, 1'b0, 8'h00);
    trigger(3, 8'h02);
    run_halt(1'b0, n);
    checks++; if (n !== 514) begin failures++; $display("FAIL parity0_halt_len got %0d exp 514", n); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL parity0_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_parity1();
    int n;
    apply_reset();
    repeat (2) cpu_cycle(3, 16'h0000, 1'b0, 8'h00);
    trigger(3, 8'h07);
    run_halt(1'b0, n);
    checks++; if (n !== 513) begin failures++; $display("FAIL parity1_halt_len got %0d exp 513", n); end
    checks++; if (dma_wdata !== mem_val(16'h07FF)) begin
      failures++; $display("FAIL parity1_last_data got %h exp %h", dma_wdata, mem_val(16'h07FF));
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL parity1_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_decoys();
    logic [15:0] addrs[4];
    logic        wes[4];
    apply_reset();
    addrs = '{16'h4015, 16'h4013, 16'h2004, 16'h4014};
    wes   = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cpu_cycle(3, addrs[i], wes[i], 8'h02);
      cpu_cycle(3, 16'h0000, 1'b0, 8'h00);
      checks++;
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
        failures++;
        $display("FAIL decoy_%h got rdy=%b act=%b exp rdy=1 act=0", addrs[i], cpu_rdy, dma_active);
      end
    end
  endtask

  task automatic test_irregular_ce();
    int n;
    apply_reset();
    cpu_cycle(12, 16'h0000, 1'b0, 8'h00);
    trigger(13, 8'h02);
    run_halt(1'b1, n);
    checks++; if (n !== 514) begin failures++; $display("FAIL irregular_halt_len got %0d exp 514", n); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL irregular_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    trigger(3, 8'h02);
    repeat (100) cpu_cycle(3, 16'h0000, 1'b0, 8'h00);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (cpu_rdy !== 1'b1 || dma_active !== 1'b0 || dma_rd !== 1'b0 || dma_we !== 1'b0 ||
        dma_addr !== 16'h0 || dma_wdata !== 8'h0) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b act=%b rd=%b we=%b addr=%h wdata=%h exp 1 0 0 0 0000 00",
               cpu_rdy, dma_active, dma_rd, dma_we, dma_addr, dma_wdata);
    end
    exp_q.delete();
    tb_par = 1'b0;
    @(posedge MCLK); #2 reset = 1'b0;
    cpu_cycle(3, 16'h0000, 1'b0, 8'h00);
    trigger(3, 8'h03);
    run_halt(1'b0, n);
    checks++; if (n !== 514) begin failures++; $display("FAIL restart_halt_len got %0d exp 514", n); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL restart_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_page_ff();
    int n;
    apply_reset();
    zero_page_hits = 0;
    trigger(3, 8'hFF);
    run_halt(1'b0, n);
    repeat (3) cpu_cycle(3, 16'h0000, 1'b0, 8'h00);
    checks++; if (n !== 513) begin failures++; $display("FAIL pageff_halt_len got %0d exp 513", n); end
    checks++; if (zero_page_hits !== 0) begin failures++; $display("FAIL pageff_wrap got %0d exp 0", zero_page_hits); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL pageff_idle got %b exp 0", dma_active); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL pageff_drain got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_parity0();
    test_parity1();
    test_decoys();
    test_irregular_ce();
    test_reset_mid();
    test_page_ff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
